// File: rtl/grayscale_pipe_if.sv
// FIFO-side bus of grayscale_pipe: read port toward the input FIFO, write port toward the output FIFO.
// master is the pipe, slave is the FIFO pair (or a testbench standing in for it).
interface grayscale_pipe_if #(
  parameter int IN_DATA_WIDTH  = 24,
  parameter int OUT_DATA_WIDTH = 8
) ();
  logic                      in_rd_en;
  logic                      in_empty;
  logic [IN_DATA_WIDTH-1:0]  in_dout;
  logic                      out_wr_en;
  logic                      out_full;
  logic [OUT_DATA_WIDTH-1:0] out_din;

  modport master (
    output in_rd_en, out_wr_en, out_din,
    input  in_empty, in_dout, out_full
  );

  modport slave (
    input  in_rd_en, out_wr_en, out_din,
    output in_empty, in_dout, out_full
  );
endinterface

// File: rtl/grayscale_pipe.sv
// Two-stage RGB-to-gray pipeline between a show-ahead input FIFO and an output FIFO.
// Define GRAYSCALE_PIPE_ROUND_EN for round-to-nearest average/weighted modes (default truncates).
module grayscale_pipe #(
  parameter int CH_WIDTH       = 8,
  parameter int IN_DATA_WIDTH  = 3 * CH_WIDTH,
  parameter int OUT_DATA_WIDTH = CH_WIDTH,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  grayscale_pipe_if.master     pipe_bus,
  output logic [CNT_WIDTH-1:0] pix_count
);

  localparam int AW = CH_WIDTH + 2;
  localparam int WW = CH_WIDTH + 9;

`ifdef GRAYSCALE_PIPE_ROUND_EN
  localparam int AVG_BIAS = 1;
  localparam int W_BIAS   = 128;
`else
  localparam int AVG_BIAS = 0;
  localparam int W_BIAS   = 0;
`endif

  logic                      s1_valid;
  logic [IN_DATA_WIDTH-1:0]  s1_rgb;
  logic [1:0]                s1_mode;
  logic                      s2_valid;
  logic [OUT_DATA_WIDTH-1:0] s2_gray;

  logic                      s2_load;
  logic                      push;
  logic                      pop;

  logic [CH_WIDTH-1:0]       r_ch;
  logic [CH_WIDTH-1:0]       g_ch;
  logic [CH_WIDTH-1:0]       b_ch;
  logic [CH_WIDTH-1:0]       hi_rg;
  logic [CH_WIDTH-1:0]       lo_rg;
  logic [CH_WIDTH-1:0]       gray_c;
  logic [AW-1:0]             avg_sum;
  logic [WW-1:0]             w_sum;

  assign s2_load = s1_valid && (!s2_valid || !pipe_bus.out_full);
  assign push    = s2_valid && !pipe_bus.out_full;
  // S1 may refill in the same cycle it hands its pixel to S2
  assign pop     = !reset && !pipe_bus.in_empty && (!s1_valid || s2_load);

  assign pipe_bus.in_rd_en  = pop;
  assign pipe_bus.out_wr_en = push;
  assign pipe_bus.out_din   = s2_gray;

  assign r_ch = s1_rgb[3*CH_WIDTH-1:2*CH_WIDTH];
  assign g_ch = s1_rgb[2*CH_WIDTH-1:CH_WIDTH];
  assign b_ch = s1_rgb[CH_WIDTH-1:0];

  always_comb begin
    avg_sum = AW'(r_ch) + AW'(g_ch) + AW'(b_ch) + AW'(AVG_BIAS);
    w_sum   = WW'(r_ch) * WW'(77) + WW'(g_ch) * WW'(150) + WW'(b_ch) * WW'(29) + WW'(W_BIAS);
    hi_rg   = (r_ch > g_ch) ? r_ch : g_ch;
    lo_rg   = (r_ch < g_ch) ? r_ch : g_ch;
    gray_c  = '0;
    case (s1_mode)
      2'd0:    gray_c = CH_WIDTH'(avg_sum / AW'(3));
      2'd1:    gray_c = CH_WIDTH'(w_sum >> 8);
      2'd2:    gray_c = (hi_rg > b_ch) ? hi_rg : b_ch;
      default: gray_c = (lo_rg < b_ch) ? lo_rg : b_ch;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_rgb    <= '0;
      s1_mode   <= '0;
      s2_valid  <= 1'b0;
      s2_gray   <= '0;
      pix_count <= '0;
    end else begin
      if (pop) begin
        s1_rgb  <= pipe_bus.in_dout;
        s1_mode <= mode;
      end
      if (pop)
        s1_valid <= 1'b1;
      else if (s2_load)
        s1_valid <= 1'b0;

      if (s2_load) begin
        s2_gray  <= OUT_DATA_WIDTH'(gray_c);
        s2_valid <= 1'b1;
      end else if (push) begin
        s2_valid <= 1'b0;
      end

      if (push)
        pix_count <= pix_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Randomized self-checking bench for grayscale_pipe against a queue-based pixel model.
// A second instance with a 4-bit counter shares the stimulus to exercise pix_count wrap.
module tb_grayscale_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        in_empty = 1'b1;
  logic [23:0] in_dout = '0;
  logic        out_full = 1'b0;
  logic [31:0] pix_count;
  logic [3:0]  pix_count_w4;

  grayscale_pipe_if #(.IN_DATA_WIDTH(24), .OUT_DATA_WIDTH(8)) bus ();
  grayscale_pipe_if #(.IN_DATA_WIDTH(24), .OUT_DATA_WIDTH(8)) bus_w4 ();

  assign bus.in_empty    = in_empty;
  assign bus.in_dout     = in_dout;
  assign bus.out_full    = out_full;
  assign bus_w4.in_empty = in_empty;
  assign bus_w4.in_dout  = in_dout;
  assign bus_w4.out_full = out_full;

  grayscale_pipe #(.CH_WIDTH(8), .IN_DATA_WIDTH(24), .OUT_DATA_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .pipe_bus  (bus),
    .pix_count (pix_count)
  );

  grayscale_pipe #(.CH_WIDTH(8), .IN_DATA_WIDTH(24), .OUT_DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w4 (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .pipe_bus  (bus_w4),
    .pix_count (pix_count_w4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] rgb;
    logic [1:0]  md;
  } src_t;

  typedef struct {
    logic [7:0] gray;
    int         pop_cyc;
  } fly_t;

  src_t       src[$];
  fly_t       fly[$];
  logic [7:0] got[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         nwr = 0;
  int         cyc = 0;
  logic       full_ctl = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_gray(input logic [23:0] p, input logic [1:0] m);
    int r, g, b, res;
`ifdef GRAYSCALE_PIPE_ROUND_EN
    int ab = 1, wb = 128;
`else
    int ab = 0, wb = 0;
`endif
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    case (m)
      2'd0:    res = (r + g + b + ab) / 3;
      2'd1:    res = (77 * r + 150 * g + 29 * b + wb) / 256;
      2'd2:    res = (r > g) ? ((r > b) ? r : b) : ((g > b) ? g : b);
      default: res = (r < g) ? ((r < b) ? r : b) : ((g < b) ? g : b);
    endcase
    return res[7:0];
  endfunction

  task automatic push_px(input logic [23:0] rgb, input logic [1:0] md);
    src.push_back('{rgb: rgb, md: md});
  endtask

  // one cycle: drive inputs after negedge, check strobes against the model, then track the pop/push
  task automatic step();
    logic exp_rd, exp_wr;
    src_t s;
    fly_t f;
    @(negedge clock);
    out_full = full_ctl;
    if (src.size() > 0) begin
      in_empty = 1'b0;
      in_dout  = src[0].rgb;
      mode     = src[0].md;
    end else begin
      in_empty = 1'b1;
      in_dout  = 24'($urandom);
      mode     = 2'($urandom);
    end
    #1;
    exp_rd = (src.size() > 0) && (fly.size() < 2 || !out_full);
    exp_wr = !out_full && (fly.size() > 0) && (fly[0].pop_cyc + 2 <= cyc);
    check_eq("in_rd_en", 32'(bus.in_rd_en), 32'(exp_rd));
    check_eq("out_wr_en", 32'(bus.out_wr_en), 32'(exp_wr));
    check_eq("pix_count", pix_count, 32'(nwr));
    check_eq("pix_count_w4", 32'(pix_count_w4), 32'(nwr & 15));
    if (bus.out_wr_en) begin
      if (fly.size() > 0) begin
        f = fly.pop_front();
        check_eq("out_din", 32'(bus.out_din), 32'(f.gray));
      end
      got.push_back(bus.out_din);
      nwr++;
    end
    if (bus.in_rd_en && src.size() > 0) begin
      s = src.pop_front();
      fly.push_back('{gray: ref_gray(s.rgb, s.md), pop_cyc: cyc});
    end
    cyc++;
  endtask

  task automatic drain();
    int guard = 0;
    full_ctl = 1'b0;
    while ((src.size() > 0 || fly.size() > 0) && guard < 300) begin
      step();
      guard++;
    end
    check_eq("drain_timeout", 32'(guard < 300), 32'd1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_empty = 1'b0;
    out_full = 1'b0;
    full_ctl = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #1;
    check_eq("rst_in_rd_en", 32'(bus.in_rd_en), 32'd0);
    check_eq("rst_out_wr_en", 32'(bus.out_wr_en), 32'd0);
    check_eq("rst_out_din", 32'(bus.out_din), 32'd0);
    check_eq("rst_pix_count", pix_count, 32'd0);
    check_eq("rst_pix_count_w4", 32'(pix_count_w4), 32'd0);
    src.delete();
    fly.delete();
    nwr      = 0;
    in_empty = 1'b1;
    reset    = 1'b0;
  endtask

  initial begin
    int base;
    int wr0;

    do_reset();

    // average of 0x10/0x20/0x30
    base = got.size();
    push_px(24'h102030, 2'd0);
    drain();
    step();
    check_eq("avg_102030", 32'(got[base]), 32'h20);
    check_eq("pix_after_one", pix_count, 32'd1);

    // weighted extremes and rounding-sensitive values
    base = got.size();
    push_px(24'hFFFFFF, 2'd1);
    push_px(24'h000000, 2'd1);
    push_px(24'h804020, 2'd1);
    push_px(24'h010100, 2'd0);
    drain();
    check_eq("wt_ffffff", 32'(got[base]), 32'hFF);
    check_eq("wt_000000", 32'(got[base+1]), 32'h00);
`ifdef GRAYSCALE_PIPE_ROUND_EN
    check_eq("wt_804020", 32'(got[base+2]), 32'h50);
    check_eq("avg_010100", 32'(got[base+3]), 32'h01);
`else
    check_eq("wt_804020", 32'(got[base+2]), 32'h4F);
    check_eq("avg_010100", 32'(got[base+3]), 32'h00);
`endif

    // max then min
    base = got.size();
    push_px(24'h3C90A1, 2'd2);
    push_px(24'h3C90A1, 2'd3);
    drain();
    check_eq("max_3c90a1", 32'(got[base]), 32'hA1);
    check_eq("min_3c90a1", 32'(got[base+1]), 32'h3C);

    // mode toggles every pixel, back to back
    for (int i = 0; i < 12; i++) push_px(24'($urandom), 2'(i));
    drain();

    // 16-pixel stream with out_full high for cycles 5..9
    wr0 = nwr;
    for (int i = 0; i < 16; i++) push_px(24'($urandom), 2'($urandom));
    for (int c = 0; c < 16; c++) begin
      full_ctl = (c >= 5 && c <= 9);
      step();
    end
    drain();
    check_eq("stall_write_count", 32'(nwr - wr0), 32'd16);

    // random traffic with random backpressure and input gaps
    for (int c = 0; c < 1500; c++) begin
      if (src.size() < 4 && $urandom_range(0, 2) != 0) push_px(24'($urandom), 2'($urandom));
      full_ctl = ($urandom_range(0, 3) == 0);
      step();
    end
    drain();

    // reset with two pixels held in flight
    push_px(24'h112233, 2'd0);
    push_px(24'h445566, 2'd2);
    full_ctl = 1'b1;
    for (int c = 0; c < 4; c++) step();
    base = got.size();
    check_eq("inflight_count", 32'(fly.size()), 32'd2);
    do_reset();
    for (int c = 0; c < 5; c++) step();
    check_eq("no_stale_writes", 32'(got.size() - base), 32'd0);

    // 17 pixels: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) push_px(24'($urandom), 2'($urandom));
    drain();
    step();
    check_eq("wrap_w4", 32'(pix_count_w4), 32'd1);
    check_eq("count_17", pix_count, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
